// File: rtl/multiply_pkg.sv
// Shared definitions for the fixed-point gain pipeline: rounding mode encoding
// and the sample/channel width derivations used by every file of the block.
package multiply_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  function automatic int calc_dw(input int h, input int w);
    return h + w;
  endfunction

  function automatic int calc_cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fixmul_round_sat.sv
// Combinational back end of the gain multiply: drops the fraction bits of the
// double-width product, optionally rounds, then saturates or wraps to DW bits.
module fixmul_round_sat
  import multiply_pkg::*;
#(
  parameter int width_H    = 5,
  parameter int width_W    = 20,
  parameter int round_mode = 0,
  parameter int sat_en     = 1,
  localparam int DW = calc_dw(width_H, width_W),
  localparam int PW = 2 * DW
) (
  input  logic signed [PW-1:0] prod_i,
  output logic signed [DW-1:0] res_o,
  output logic                 ovf_o
);

  // One guard bit keeps the rounding add from wrapping on the most positive product.
  localparam int EW = PW + 1;

  logic signed [EW-1:0] shifted;
  logic                 ovf_w;

  function automatic logic signed [EW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] half;
    ext  = {p[PW-1], p};
    half = '0;
    half[width_W-1] = 1'b1;
    if (round_mode == int'(RND_HALF_UP)) ext = ext + half;
    return ext >>> width_W;
  endfunction

  function automatic logic out_of_range(input logic signed [EW-1:0] s);
    return !((&s[EW-1:DW-1]) || !(|s[EW-1:DW-1]));
  endfunction

  function automatic logic signed [DW-1:0] limit(input logic signed [EW-1:0] s,
                                                 input logic ovf);
    if (ovf && (sat_en != 0)) begin
      return s[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    return s[DW-1:0];
  endfunction

  always_comb begin
    shifted = round_shift(prod_i);
    ovf_w   = out_of_range(shifted);
    res_o   = limit(shifted, ovf_w);
    ovf_o   = ovf_w;
  end

endmodule

// File: rtl/multiply_gain_pipe.sv
// Per-channel fixed-point gain: data_o = data_i * coef[ch], two register stages,
// with a writable coefficient table and a sticky overflow flag.
module multiply_gain_pipe
  import multiply_pkg::*;
#(
  parameter int width_H    = 5,
  parameter int width_W    = 20,
  parameter int ch_num     = 4,
  parameter int const_num  = 6553,
  parameter int round_mode = 0,
  parameter int sat_en     = 1,
  localparam int DW = calc_dw(width_H, width_W),
  localparam int CW = calc_cw(ch_num)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_i_en,
  input  logic signed [DW-1:0] data_i,
  input  logic        [CW-1:0] data_i_ch,
  input  logic                 coef_wr_en,
  input  logic        [CW-1:0] coef_wr_ch,
  input  logic signed [DW-1:0] coef_wr_data,
  input  logic                 ovf_clr,
  output logic                 data_o_en,
  output logic signed [DW-1:0] data_o,
  output logic        [CW-1:0] data_o_ch,
  output logic                 ovf_o
);

  localparam int PW       = 2 * DW;
  localparam int CH_SLOTS = 1 << CW;
  localparam logic signed [DW-1:0] COEF_RST = DW'(const_num);

  logic signed [DW-1:0] coef_q [CH_SLOTS];
  logic signed [DW-1:0] coef_d [CH_SLOTS];
  logic signed [DW-1:0] coef_sel;
  logic signed [PW-1:0] data_ext;
  logic signed [PW-1:0] coef_ext;

  logic                 vld_p1_q, vld_p1_d;
  logic signed [PW-1:0] prod_p1_q, prod_p1_d;
  logic        [CW-1:0] ch_p1_q, ch_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic signed [DW-1:0] data_p2_q, data_p2_d;
  logic        [CW-1:0] ch_p2_q, ch_p2_d;
  logic                 ovf_q, ovf_d;

  logic signed [DW-1:0] res_p1;
  logic                 ovf_p1;

  // Stage 0 -> 1: coefficient lookup (pre-write value) and full-width product.
  always_comb begin
    coef_d = coef_q;
    if (coef_wr_en && (int'(coef_wr_ch) < ch_num)) coef_d[coef_wr_ch] = coef_wr_data;

    coef_sel  = (int'(data_i_ch) < ch_num) ? coef_q[data_i_ch] : '0;
    data_ext  = {{DW{data_i[DW-1]}}, data_i};
    coef_ext  = {{DW{coef_sel[DW-1]}}, coef_sel};
    prod_p1_d = data_ext * coef_ext;
    ch_p1_d   = data_i_ch;
    vld_p1_d  = data_i_en;
  end

  fixmul_round_sat #(
    .width_H    (width_H),
    .width_W    (width_W),
    .round_mode (round_mode),
    .sat_en     (sat_en)
  ) u_round_sat (
    .prod_i (prod_p1_q),
    .res_o  (res_p1),
    .ovf_o  (ovf_p1)
  );

  // Stage 1 -> 2: scaled result, outputs hold between valid samples.
  always_comb begin
    vld_p2_d  = vld_p1_q;
    data_p2_d = data_p2_q;
    ch_p2_d   = ch_p2_q;
    if (vld_p1_q) begin
      data_p2_d = res_p1;
      ch_p2_d   = ch_p1_q;
    end
    ovf_d = (vld_p1_q && ovf_p1) || (ovf_q && !ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      ch_p2_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < CH_SLOTS; i++) coef_q[i] <= COEF_RST;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      ch_p2_q   <= ch_p2_d;
      ovf_q     <= ovf_d;
      coef_q    <= coef_d;
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    ch_p1_q   <= ch_p1_d;
  end

  assign data_o_en = vld_p2_q;
  assign data_o    = data_p2_q;
  assign data_o_ch = ch_p2_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_multiply_gain_pipe.sv
// Bench for multiply_gain_pipe: two instances (truncate+saturate with 4 channels,
// round+wrap with 3 channels) driven alike and checked against a queue model.
module tb_multiply_gain_pipe;

  localparam int H  = 5;
  localparam int W  = 20;
  localparam int DW = 25;
  localparam int CW = 2;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                 data_i_en = 1'b0;
  logic signed [DW-1:0] data_i = '0;
  logic        [CW-1:0] data_i_ch = '0;
  logic                 coef_wr_en = 1'b0;
  logic        [CW-1:0] coef_wr_ch = '0;
  logic signed [DW-1:0] coef_wr_data = '0;
  logic                 ovf_clr = 1'b0;

  logic                 den  [2];
  logic signed [DW-1:0] dout [2];
  logic        [CW-1:0] dch  [2];
  logic                 dovf [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiply_gain_pipe #(
    .width_H(H), .width_W(W), .ch_num(4), .const_num(6553), .round_mode(0), .sat_en(1)
  ) u0 (
    .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i(data_i), .data_i_ch(data_i_ch),
    .coef_wr_en(coef_wr_en), .coef_wr_ch(coef_wr_ch), .coef_wr_data(coef_wr_data),
    .ovf_clr(ovf_clr), .data_o_en(den[0]), .data_o(dout[0]), .data_o_ch(dch[0]),
    .ovf_o(dovf[0])
  );

  multiply_gain_pipe #(
    .width_H(H), .width_W(W), .ch_num(3), .const_num(6553), .round_mode(1), .sat_en(0)
  ) u1 (
    .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i(data_i), .data_i_ch(data_i_ch),
    .coef_wr_en(coef_wr_en), .coef_wr_ch(coef_wr_ch), .coef_wr_data(coef_wr_data),
    .ovf_clr(ovf_clr), .data_o_en(den[1]), .data_o(dout[1]), .data_o_ch(dch[1]),
    .ovf_o(dovf[1])
  );

  // Reference model: results computed on acceptance, released one edge later.
  typedef struct {
    int     due;
    longint r0;
    longint r1;
    bit     o0;
    bit     o1;
    int     ch;
  } item_t;

  item_t  q[$];
  longint coef_m [2][4];
  int     chn  [2] = '{4, 3};
  int     rmv  [2] = '{0, 1};
  int     satv [2] = '{1, 0};
  bit     exp_en  [2] = '{0, 0};
  longint exp_d   [2] = '{0, 0};
  int     exp_ch  [2] = '{0, 0};
  bit     exp_ovf [2] = '{0, 0};
  int     cyc = 0;

  function automatic void calc(input longint d, input longint c, input int rm, input int sat,
                               output longint r, output bit o);
    longint p;
    longint s;
    p = d * c;
    if (rm != 0) p = p + (longint'(1) <<< (W - 1));
    s = p >>> W;
    o = (s > MAXV) || (s < MINV);
    if (!o) r = s;
    else if (sat != 0) r = (s > MAXV) ? MAXV : MINV;
    else begin
      r = s & ((longint'(1) <<< DW) - 1);
      if (r > MAXV) r = r - (longint'(1) <<< DW);
    end
  endfunction

  always @(posedge clk) begin : model
    item_t  it;
    bit     pset [2];
    longint c;
    longint r;
    bit     o;
    int     ch;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 2; i++) begin
        exp_en[i] = 0; exp_d[i] = 0; exp_ch[i] = 0; exp_ovf[i] = 0;
        for (int k = 0; k < 4; k++) coef_m[i][k] = 6553;
      end
    end else begin
      pset[0] = 0; pset[1] = 0;
      exp_en[0] = 0; exp_en[1] = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        it = q.pop_front();
        exp_en[0] = 1; exp_en[1] = 1;
        exp_d[0] = it.r0; exp_d[1] = it.r1;
        exp_ch[0] = it.ch; exp_ch[1] = it.ch;
        pset[0] = it.o0; pset[1] = it.o1;
      end
      for (int i = 0; i < 2; i++) exp_ovf[i] = pset[i] || (exp_ovf[i] && !ovf_clr);
      if (data_i_en) begin
        ch = int'(data_i_ch);
        it.due = cyc + 1;
        it.ch  = ch;
        for (int i = 0; i < 2; i++) begin
          c = (ch < chn[i]) ? coef_m[i][ch] : 0;
          calc(longint'(data_i), c, rmv[i], satv[i], r, o);
          if (i == 0) begin it.r0 = r; it.o0 = o; end
          else begin it.r1 = r; it.o1 = o; end
        end
        q.push_back(it);
      end
      if (coef_wr_en) begin
        for (int i = 0; i < 2; i++)
          if (int'(coef_wr_ch) < chn[i]) coef_m[i][int'(coef_wr_ch)] = longint'(coef_wr_data);
      end
    end
    cyc++;
  end

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic sb_check();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sb_en_u%0d_c%0d", i, cyc), den[i], exp_en[i]);
      chk($sformatf("sb_data_u%0d_c%0d", i, cyc), dout[i], exp_d[i]);
      chk($sformatf("sb_ch_u%0d_c%0d", i, cyc), dch[i], exp_ch[i]);
      chk($sformatf("sb_ovf_u%0d_c%0d", i, cyc), dovf[i], exp_ovf[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
    sb_check();
  endtask

  task automatic pulse_sample(input longint d, input int ch);
    data_i_en = 1'b1;
    data_i    = DW'(d);
    data_i_ch = CW'(ch);
    step();
    data_i_en = 1'b0;
    step();
  endtask

  task automatic wr(input int ch, input longint v);
    coef_wr_en   = 1'b1;
    coef_wr_ch   = CW'(ch);
    coef_wr_data = DW'(v);
    step();
    coef_wr_en = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (3) step();
    chk("rst_en", den[0], 0);
    chk("rst_data", dout[0], 0);
    chk("rst_ovf", dovf[1], 0);
    rst = 1'b0;

    pulse_sample(1048576, 0);
    chk("unity_en", den[0], 1);
    chk("unity_data", dout[0], 6553);
    chk("unity_ch", dch[0], 0);
    step();
    chk("unity_single_pulse", den[0], 0);
    chk("unity_hold", dout[0], 6553);

    wr(2, 524288);
    pulse_sample(3, 2);
    chk("half_pos_trunc", dout[0], 1);
    chk("half_pos_round", dout[1], 2);
    pulse_sample(-3, 2);
    chk("half_neg_trunc", dout[0], -2);
    chk("half_neg_round", dout[1], -1);

    wr(1, 2097152);
    pulse_sample(16777215, 1);
    chk("sat_data", dout[0], 16777215);
    chk("sat_ovf", dovf[0], 1);
    chk("wrap_data", dout[1], -2);
    chk("wrap_ovf", dovf[1], 1);
    repeat (3) step();
    chk("ovf_sticky0", dovf[0], 1);
    chk("ovf_sticky1", dovf[1], 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", dovf[0], 0);
    data_i_en = 1'b1; data_i = DW'(16777215); data_i_ch = CW'(1);
    step();
    data_i_en = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_set_wins0", dovf[0], 1);
    chk("ovf_set_wins1", dovf[1], 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    coef_wr_en = 1'b1; coef_wr_ch = CW'(3); coef_wr_data = DW'(-1048576);
    data_i_en = 1'b1; data_i = DW'(1000); data_i_ch = CW'(3);
    step();
    coef_wr_en = 1'b0;
    step();
    chk("wr_same_edge_old", dout[0], 6);
    chk("wr_same_edge_tag", dch[0], 3);
    chk("bad_ch_coef0", dout[1], 0);
    chk("bad_ch_tag", dch[1], 3);
    data_i_en = 1'b0;
    step();
    chk("wr_next_new", dout[0], -1000);

    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      data_i_en = 1'b1; data_i = DW'(1048576); data_i_ch = CW'(k);
      step();
      if (den[0] === 1'b1) cnt++;
    end
    data_i_en = 1'b0;
    repeat (3) begin
      step();
      if (den[0] === 1'b1) cnt++;
    end
    chk("b2b_pulses", cnt, 4);

    data_i_en = 1'b1; data_i = DW'(1048576); data_i_ch = CW'(0);
    step();
    rst = 1'b1;
    data_i_en = 1'b0;
    repeat (3) begin
      step();
      chk("midrst_en", den[0], 0);
      chk("midrst_data", dout[0], 0);
    end
    rst = 1'b0;
    pulse_sample(1048576, 2);
    chk("coef_reloaded0", dout[0], 6553);
    chk("coef_reloaded1", dout[1], 6553);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiply_gain_pipe.md
MULTIPLY_GAIN_PIPE -- requirements
Module: multiply_gain_pipe

Interface
REQ-001 SHALL have parameter width_H, default 5, integer bits including sign.
REQ-002 SHALL have parameter width_W, default 20, fraction bits; sample width DW = width_H+width_W.
REQ-003 SHALL have parameter ch_num, default 4, channel count (1..16); CW = max(1,clog2(ch_num)).
REQ-004 SHALL have parameter const_num, default 6553, reset value of every channel coefficient.
REQ-005 SHALL have parameter round_mode, default 0, 0 = truncate (floor), 1 = round-half-up.
REQ-006 SHALL have parameter sat_en, default 1, 1 = saturate, 0 = two's-complement wrap.
REQ-007 SHALL have clk  input  1  sole clock, rising edge.
REQ-008 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have data_i_en  input  1  input sample valid.
REQ-010 SHALL have data_i  input  DW  signed Q(width_H.width_W) sample.
REQ-011 SHALL have data_i_ch  input  CW  channel of data_i.
REQ-012 SHALL have coef_wr_en  input  1  coefficient write strobe.
REQ-013 SHALL have coef_wr_ch  input  CW  channel to write.
REQ-014 SHALL have coef_wr_data  input  DW  signed Q coefficient.
REQ-015 SHALL have ovf_clr  input  1  clear sticky overflow.
REQ-016 SHALL have data_o_en  output  1  output valid, one pulse per accepted sample.
REQ-017 SHALL have data_o  output  DW  signed scaled result.
REQ-018 SHALL have data_o_ch  output  CW  channel tag of data_o.
REQ-019 SHALL have ovf_o  output  1  sticky overflow flag.

Function
REQ-020 SHALL accept a sample on every rising edge with data_i_en=1; no backpressure, throughput one sample per cycle.
REQ-021 SHALL present the result exactly 2 cycles after acceptance: stage 1 registers the full 2*DW signed product, stage 2 registers the shifted, rounded and limited result.
REQ-022 SHALL compute product = signed(data_i) * signed(coef[data_i_ch]) at full 2*DW width, with no intermediate truncation.
REQ-023 SHALL form the result as an arithmetic right shift of the product by width_W; with round_mode=1 it SHALL add 2^(width_W-1) before the shift.
REQ-024 SHALL, with sat_en=1, clamp the result to [-2^(DW-1), 2^(DW-1)-1]; with sat_en=0 it SHALL keep the low DW bits.
REQ-025 SHALL set ovf_o when a stage-2 result is out of range, regardless of sat_en.
REQ-026 SHALL clear ovf_o on ovf_clr=1; when a set and a clear occur in the same cycle, the set wins.
REQ-027 SHALL drive data_o_en low on cycles without a result, and SHALL hold data_o and data_o_ch at their last values.
REQ-028 SHALL apply a coefficient write on the clock edge; a sample accepted on that same edge for the same channel SHALL use the old coefficient.
REQ-029 SHALL ignore a coef_wr_ch or data_i_ch value of ch_num or above: no write takes place, and the sample uses coefficient 0 with its tag passed through unchanged.
REQ-030 SHALL carry data_i_ch through the pipeline aligned with its sample.

Reset
REQ-031 SHALL, while rst=1, force data_o_en=0, data_o=0, data_o_ch=0, ovf_o=0, clear all pipeline valid bits, and load every coefficient with const_num.
REQ-032 SHALL discard samples in flight when rst is asserted mid-operation; no data_o_en pulse SHALL result from them.
REQ-033 SHALL accept the first sample on the first rising edge after rst deasserts.

Structure
REQ-034 SHALL take the round_mode encoding enum and the DW/CW derivation helpers from package multiply_pkg.
REQ-035 SHALL instantiate one sub-module, fixmul_round_sat, which is purely combinational and performs shift, round, limit and overflow detection for stage 2.

Verification
REQ-036 Defaults, all coefficients at reset: data_i=1048576 (1.0) on ch0 -> data_o=6553, data_o_ch=0 and a single data_o_en pulse 2 cycles later.
REQ-037 Write coef ch2=524288, then data_i=3 on ch2 -> data_o=1 with round_mode=0; data_o=2 with round_mode=1.
REQ-038 Coef ch2=524288, data_i=-3 -> data_o=-2 with round_mode=0; data_o=-1 with round_mode=1.
REQ-039 Coef ch1=2097152 (2.0), data_i=16777215 -> data_o=16777215 and ovf_o=1 with sat_en=1; data_o=-2 and ovf_o=1 with sat_en=0; ovf_o stays 1 until ovf_clr.
REQ-040 Coefficient write to ch3 on the same edge as a ch3 sample -> that sample uses the old coefficient and the next one uses the new; back-to-back samples on ch0..3 -> four consecutive pulses with correct tags.
REQ-041 Assert rst one cycle after a sample is accepted -> no data_o_en pulse, all outputs 0, coefficients back to 6553.
